// File: rtl/react_game_fsm.sv
// ---------------------------------------------------------------------------
// react_game_fsm
// Reaction-time game controller feeding the VGA drawing FSM. Sequences
// menu (blue) -> wait (red, random length) -> go (green) -> score screens and
// measures the player's reaction time in milliseconds from green onset.
//
// Ports
//   clk           system clock
//   iResetn       synchronous reset, active-low
//   keyPress      player key (level, already synchronised, active-high)
//   reactScreen   0=menu 1=wait 2=go 3=score (registered copy of the state)
//   currentScore  last reaction time in ms (0 after an early press)
//   oScoreValid   one-cycle pulse in the cycle the score screen is entered
//   oEarly        high while on the score screen after a premature press
//   oBestScore    best (lowest) valid score since reset
//
// Optional feature macro: REACT_BEST_EN
//   defined   -> oBestScore tracks the lowest non-early, non-zero score
//   undefined -> oBestScore is tied to zero, no best-score register
// ---------------------------------------------------------------------------
module react_game_fsm #(
  parameter int TICKS_PER_MS = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int MAX_SCORE    = 999
) (
  input  logic        clk,
  input  logic        iResetn,
  input  logic        keyPress,
  output logic [1:0]  reactScreen,
  output logic [11:0] currentScore,
  output logic        oScoreValid,
  output logic        oEarly,
  output logic [11:0] oBestScore
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  typedef enum logic [1:0] {
    S_MENU  = 2'd0,
    S_WAIT  = 2'd1,
    S_GO    = 2'd2,
    S_SCORE = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          keyPrev_r;
  logic          press_r;
  logic [15:0]   lfsr_r;
  logic [PW-1:0] prescaler_r;
  logic [PW-1:0] prescaler_s;
  logic          msTick_s;
  logic [11:0]   delayMs_r;
  logic [11:0]   delayMs_s;
  logic [11:0]   msCount_r;
  logic [11:0]   msCount_s;
  logic [11:0]   score_s;
  logic          early_s;
  logic          scoreValid_s;

  // Fibonacci LFSR step, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form).
  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  assign msTick_s = (prescaler_r == PW'(TICKS_PER_MS - 1));

  // Next-state and next-datapath logic for the game sequencer.
  always_comb begin
    state_s      = state_r;
    delayMs_s    = delayMs_r;
    msCount_s    = msCount_r;
    score_s      = currentScore;
    early_s      = oEarly;
    scoreValid_s = 1'b0;
    if (msTick_s) begin
      prescaler_s = '0;
    end else begin
      prescaler_s = prescaler_r + PW'(1);
    end
    case (state_r)
      S_MENU: begin
        if (press_r) begin
          state_s     = S_WAIT;
          delayMs_s   = 12'(MIN_DELAY_MS) + 12'(lfsr_r[RAND_BITS-1:0]);
          prescaler_s = '0;
        end else begin
          state_s = S_MENU;
        end
      end
      S_WAIT: begin
        // A press beats an expiry landing in the same cycle.
        if (press_r) begin
          state_s      = S_SCORE;
          score_s      = 12'd0;
          early_s      = 1'b1;
          scoreValid_s = 1'b1;
        end else if (msTick_s) begin
          // The tick that would take the count to zero ends the wait.
          if (delayMs_r <= 12'd1) begin
            state_s     = S_GO;
            msCount_s   = 12'd0;
            prescaler_s = '0;
          end else begin
            delayMs_s = delayMs_r - 12'd1;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_GO: begin
        // Press coincident with a tick reports the pre-increment count.
        if (press_r) begin
          state_s      = S_SCORE;
          score_s      = msCount_r;
          early_s      = 1'b0;
          scoreValid_s = 1'b1;
        end else if (msTick_s) begin
          if (msCount_r >= 12'(MAX_SCORE - 1)) begin
            state_s      = S_SCORE;
            msCount_s    = 12'(MAX_SCORE);
            score_s      = 12'(MAX_SCORE);
            early_s      = 1'b0;
            scoreValid_s = 1'b1;
          end else begin
            msCount_s = msCount_r + 12'd1;
          end
        end else begin
          state_s = S_GO;
        end
      end
      S_SCORE: begin
        if (press_r) begin
          state_s = S_MENU;
          early_s = 1'b0;
        end else begin
          state_s = S_SCORE;
        end
      end
      default: begin
        state_s = S_MENU;
        early_s = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!iResetn) begin
      state_r      <= S_MENU;
      reactScreen  <= 2'd0;
      keyPrev_r    <= 1'b0;
      press_r      <= 1'b0;
      lfsr_r       <= 16'hACE1;
      prescaler_r  <= '0;
      delayMs_r    <= 12'd0;
      msCount_r    <= 12'd0;
      currentScore <= 12'd0;
      oScoreValid  <= 1'b0;
      oEarly       <= 1'b0;
    end else begin
      state_r      <= state_s;
      reactScreen  <= state_s;
      keyPrev_r    <= keyPress;
      press_r      <= keyPress & ~keyPrev_r;
      lfsr_r       <= lfsrStep(lfsr_r);
      prescaler_r  <= prescaler_s;
      delayMs_r    <= delayMs_s;
      msCount_r    <= msCount_s;
      currentScore <= score_s;
      oScoreValid  <= scoreValid_s;
      oEarly       <= early_s;
    end
  end

`ifdef REACT_BEST_EN
  logic [11:0] best_r;

  // Best-score tracker; zero means no valid score yet.
  always_ff @(posedge clk) begin
    if (!iResetn) begin
      best_r <= 12'd0;
    end else if (scoreValid_s && !early_s && (score_s != 12'd0) &&
                 ((best_r == 12'd0) || (score_s < best_r))) begin
      best_r <= score_s;
    end else begin
      best_r <= best_r;
    end
  end

  assign oBestScore = best_r;
`else
  assign oBestScore = 12'd0;
`endif

endmodule

// File: tb/tb_react_game_fsm.sv
// ---------------------------------------------------------------------------
// tb_react_game_fsm
// Self-checking bench for react_game_fsm with small timing parameters.
// Expected values come from a reference model built on cycle arithmetic:
// green arrives 4*delay cycles after red, the score is the number of whole
// milliseconds elapsed before the press acted, and the best score is the
// minimum of valid scores. Honours REACT_BEST_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_react_game_fsm;

  localparam int TPM  = 4;
  localparam int MIN  = 2;
  localparam int RB   = 2;
  localparam int MAXS = 20;
`ifdef REACT_BEST_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        iResetn = 1'b0;
  logic        keyPress = 1'b0;
  logic [1:0]  reactScreen;
  logic [11:0] currentScore;
  logic        oScoreValid;
  logic        oEarly;
  logic [11:0] oBestScore;

  int compared = 0;
  int mismatched = 0;
  int edgeNum = 0;
  int bestModel = 0;
  int heldScore = 0;
  logic [15:0] lfsrModel = 16'hACE1;
  logic [15:0] lfsrBefore = 16'hACE1;

  react_game_fsm #(
    .TICKS_PER_MS(TPM),
    .MIN_DELAY_MS(MIN),
    .RAND_BITS(RB),
    .MAX_SCORE(MAXS)
  ) dut (
    .clk(clk),
    .iResetn(iResetn),
    .keyPress(keyPress),
    .reactScreen(reactScreen),
    .currentScore(currentScore),
    .oScoreValid(oScoreValid),
    .oEarly(oEarly),
    .oBestScore(oBestScore)
  );

  always #5 clk = ~clk;

  // Edge counter plus the LFSR sequence (taps 16,14,13,11, seed ACE1).
  always @(posedge clk) begin
    edgeNum <= edgeNum + 1;
    lfsrBefore <= lfsrModel;
    if (!iResetn) lfsrModel <= 16'hACE1;
    else lfsrModel <= {lfsrModel[0] ^ lfsrModel[2] ^ lfsrModel[3] ^ lfsrModel[5], lfsrModel[15:1]};
  end

  function automatic int expBest();
    return BEST_EN ? bestModel : 0;
  endfunction

  // Press: raise key for one cycle; returns at the negedge after the FSM reacted.
  task automatic pressKey(input bit hold);
    keyPress = 1'b1;
    @(negedge clk);
    if (!hold) keyPress = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitScreen(input logic [1:0] target, input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (reactScreen == target) begin
        ok = 1'b1;
        at = edgeNum;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iResetn = 1'b0;
    keyPress = 1'b0;
    repeat (2) @(negedge clk);
    iResetn = 1'b1;
    @(negedge clk);
    bestModel = 0;
    heldScore = 0;
    compared++; if (reactScreen !== 2'd0) begin mismatched++; $display("FAIL reset_screen: got %0d want 0", reactScreen); end
    compared++; if (currentScore !== 12'd0) begin mismatched++; $display("FAIL reset_score: got %0d want 0", currentScore); end
    compared++; if (oScoreValid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", oScoreValid); end
    compared++; if (oEarly !== 1'b0) begin mismatched++; $display("FAIL reset_early: got %0b want 0", oEarly); end
    compared++; if (oBestScore !== 12'd0) begin mismatched++; $display("FAIL reset_best: got %0d want 0", oBestScore); end
  endtask

  // From MENU: press, then expect green 4*(MIN + lfsr[RB-1:0]) cycles later.
  task automatic test_wait_to_go(input bit hold, output int greenAt);
    int e, d, expG;
    bit ok;
    pressKey(hold);
    e = edgeNum;
    d = MIN + int'(lfsrBefore[RB-1:0]);
    expG = e + TPM * d;
    compared++; if (reactScreen !== 2'd1) begin mismatched++; $display("FAIL enter_wait: got %0d want 1", reactScreen); end
    waitScreen(2'd2, TPM * d + 4, greenAt, ok);
    compared++;
    if (!ok || greenAt < expG - 1 || greenAt > expG + 1) begin
      mismatched++;
      $display("FAIL green_time: got edge %0d want %0d (ok=%0b)", greenAt, expG, ok);
    end
    if (!ok) greenAt = expG;
  endtask

  // In GO: the press acts d cycles after green; d beyond the timeout means no press.
  task automatic test_go_press(input int greenAt, input int d);
    int expScore, expAt, at;
    bit ok;
    if (d <= TPM * MAXS) begin
      while (edgeNum < greenAt + d - 2) @(negedge clk);
      pressKey(1'b0);
      at = edgeNum;
      ok = 1'b1;
      expAt = greenAt + d;
      expScore = (d - 1) / TPM;
    end else begin
      keyPress = 1'b0;
      waitScreen(2'd3, TPM * MAXS + 4, at, ok);
      expAt = greenAt + TPM * MAXS;
      expScore = MAXS;
    end
    if (expScore != 0 && (bestModel == 0 || expScore < bestModel)) bestModel = expScore;
    heldScore = expScore;
    compared++; if (!ok || at != expAt || reactScreen !== 2'd3) begin mismatched++; $display("FAIL score_entry: screen %0d at edge %0d want 3 at %0d", reactScreen, at, expAt); end
    compared++; if (currentScore !== 12'(expScore)) begin mismatched++; $display("FAIL score_value: got %0d want %0d (d=%0d)", currentScore, expScore, d); end
    compared++; if (oScoreValid !== 1'b1) begin mismatched++; $display("FAIL valid_pulse: got %0b want 1", oScoreValid); end
    compared++; if (oEarly !== 1'b0) begin mismatched++; $display("FAIL go_early: got %0b want 0", oEarly); end
    compared++; if (oBestScore !== 12'(expBest())) begin mismatched++; $display("FAIL best_score: got %0d want %0d", oBestScore, expBest()); end
    @(negedge clk);
    compared++; if (oScoreValid !== 1'b0) begin mismatched++; $display("FAIL valid_width: got %0b want 0", oScoreValid); end
  endtask

  task automatic test_leave_score();
    pressKey(1'b0);
    compared++; if (reactScreen !== 2'd0) begin mismatched++; $display("FAIL leave_score: got %0d want 0", reactScreen); end
    compared++; if (oEarly !== 1'b0) begin mismatched++; $display("FAIL early_clear: got %0b want 0", oEarly); end
    compared++; if (currentScore !== 12'(heldScore)) begin mismatched++; $display("FAIL score_held: got %0d want %0d", currentScore, heldScore); end
  endtask

  task automatic test_early(input int extra);
    pressKey(1'b0);
    compared++; if (reactScreen !== 2'd1) begin mismatched++; $display("FAIL early_wait: got %0d want 1", reactScreen); end
    repeat (extra) @(negedge clk);
    pressKey(1'b0);
    heldScore = 0;
    compared++; if (reactScreen !== 2'd3) begin mismatched++; $display("FAIL early_screen: got %0d want 3", reactScreen); end
    compared++; if (currentScore !== 12'd0) begin mismatched++; $display("FAIL early_score: got %0d want 0", currentScore); end
    compared++; if (oEarly !== 1'b1) begin mismatched++; $display("FAIL early_flag: got %0b want 1", oEarly); end
    compared++; if (oScoreValid !== 1'b1) begin mismatched++; $display("FAIL early_valid: got %0b want 1", oScoreValid); end
    compared++; if (oBestScore !== 12'(expBest())) begin mismatched++; $display("FAIL early_best: got %0d want %0d", oBestScore, expBest()); end
    test_leave_score();
  endtask

  task automatic test_best();
    int g;
    test_wait_to_go(1'b0, g); test_go_press(g, 41); test_leave_score();
    test_wait_to_go(1'b0, g); test_go_press(g, 29); test_leave_score();
    test_wait_to_go(1'b0, g); test_go_press(g, 49); test_leave_score();
    test_early(1);
  endtask

  // Key held through WAIT must not abort; timeout then key held across SCORE->MENU.
  task automatic test_timeout_hold();
    int g, bad;
    test_wait_to_go(1'b1, g);
    keyPress = 1'b0;
    test_go_press(g, 1000);
    pressKey(1'b1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (reactScreen != 2'd0) bad++;
      @(negedge clk);
    end
    compared++; if (bad != 0 || reactScreen !== 2'd0) begin mismatched++; $display("FAIL hold_menu: %0d cycles off menu, screen %0d want 0", bad, reactScreen); end
    keyPress = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int g;
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        test_early(int'($urandom_range(0, 3)));
      end else begin
        test_wait_to_go(1'b0, g);
        test_go_press(g, int'($urandom_range(2, TPM * MAXS + 6)));
        test_leave_score();
      end
    end
  endtask

  task automatic test_reset_mid_go();
    int g;
    test_wait_to_go(1'b0, g); test_go_press(g, 41); test_leave_score();
    test_wait_to_go(1'b0, g);
    repeat (6) @(negedge clk);
    iResetn = 1'b0;
    @(negedge clk);
    bestModel = 0;
    heldScore = 0;
    compared++; if (reactScreen !== 2'd0) begin mismatched++; $display("FAIL midreset_screen: got %0d want 0", reactScreen); end
    compared++; if (currentScore !== 12'd0) begin mismatched++; $display("FAIL midreset_score: got %0d want 0", currentScore); end
    compared++; if (oEarly !== 1'b0 || oScoreValid !== 1'b0) begin mismatched++; $display("FAIL midreset_flags: early %0b valid %0b want 0 0", oEarly, oScoreValid); end
    compared++; if (oBestScore !== 12'd0) begin mismatched++; $display("FAIL midreset_best: got %0d want 0", oBestScore); end
    iResetn = 1'b1;
    @(negedge clk);
    test_wait_to_go(1'b0, g); test_go_press(g, 13); test_leave_score();
  endtask

  initial begin
    test_reset();
    test_best();
    test_timeout_hold();
    test_random();
    test_reset_mid_go();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
